// File: rtl/apu_frame_seq.sv
// APU frame sequencer: turns falling edges of a DIV tap into 512 Hz step events and
// issues one-clock length/sweep/envelope strobes on an 8-step schedule.
module apu_frame_seq (
    input  logic       i_clk,
    input  logic       i_nreset,
    input  logic       i_div_bit,
    input  logic       i_apu_on,
    input  logic       i_test_fast,
    output logic       o_len_tick,
    output logic       o_sweep_tick,
    output logic       o_env_tick,
    output logic [2:0] o_step,
    output logic       o_len_next
);

    logic       r_s0;
    logic       r_s1;
    logic       r_apu_q;
    logic       r_skip;
    logic [2:0] r_step;
    logic       r_len;
    logic       r_sweep;
    logic       r_env;

    logic       w_event;
    logic       w_skip;
    logic       w_skip_d;
    logic [2:0] w_step_d;
    logic       w_len_d;
    logic       w_sweep_d;
    logic       w_env_d;

    assign w_event = i_test_fast | (r_s1 & ~r_s0);
    // Power-on while the tap is already high: the first falling edge is not a real step.
    assign w_skip  = r_skip | (i_apu_on & ~r_apu_q & r_s0);

    always_comb begin
        w_skip_d  = w_skip;
        w_step_d  = r_step;
        w_len_d   = 1'b0;
        w_sweep_d = 1'b0;
        w_env_d   = 1'b0;
        if (!i_apu_on) begin
            w_skip_d = 1'b0;
            w_step_d = 3'd0;
        end else if (w_event) begin
            if (w_skip) begin
                w_skip_d = 1'b0;
            end else begin
                w_step_d = r_step + 3'd1;
                case (r_step)
                    3'd0, 3'd4: w_len_d = 1'b1;
                    3'd2, 3'd6: begin
                        w_len_d   = 1'b1;
                        w_sweep_d = 1'b1;
                    end
                    3'd7:    w_env_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_apu_q <= 1'b0;
            r_skip  <= 1'b0;
            r_step  <= 3'd0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end else begin
            r_s0    <= i_div_bit;
            r_s1    <= r_s0;
            r_apu_q <= i_apu_on;
            r_skip  <= w_skip_d;
            r_step  <= w_step_d;
            r_len   <= w_len_d;
            r_sweep <= w_sweep_d;
            r_env   <= w_env_d;
        end
    end

    assign o_len_tick   = r_len;
    assign o_sweep_tick = r_sweep;
    assign o_env_tick   = r_env;
    assign o_step       = r_step;
    assign o_len_next   = ~r_step[0];

endmodule
